reg_file_debug_port: RTL and testbench
======================================

# reg_file_debug_port

Command-driven initiator for the 16×8 two-read/one-write register file. It turns single-beat debug commands into cycle-accurate register-file port activity: single read, single write, full dump and full clear. Read data is returned on a valid/ready response channel. It sits between the debug/host link and the register file's `ra`/`read_a` and `wa`/`wd`/`we` ports; the core-versus-debug port mux is external.

## Interface
Parameters:
- `ADDR_W`, 4, register address width
- `DATA_W`, 8, register data width
- `NUM_REGS`, 16, registers swept by DUMP/CLEAR; always 2^ADDR_W

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  block accepts a command this cycle
- `cmd_op`  in  2  00 READ, 01 WRITE, 10 DUMP, 11 CLEAR
- `cmd_addr`  in  ADDR_W  target register (READ/WRITE)
- `cmd_data`  in  DATA_W  write data (WRITE)
- `rsp_valid`  out  1  response beat present
- `rsp_ready`  in  1  consumer takes beat
- `rsp_data`  out  DATA_W  read value
- `rsp_addr`  out  ADDR_W  register the value came from
- `rsp_last`  out  1  final beat of the command
- `busy`  out  1  command in progress (not IDLE)
- `rf_ra`  out  ADDR_W  to register file `ra`
- `rf_rdata`  in  DATA_W  from register file `read_a` (combinational read)
- `rf_wa`, `rf_wd`, `rf_we`  out  ADDR_W/DATA_W/1  to register file write port

## Operation
- States: IDLE, WR, RD, RSP, DMP_RD, DMP_RSP, CLR, CSUM (CSUM exists only with the macro).
- IDLE: `cmd_ready`=1. A command is accepted on a rising edge with `cmd_valid && cmd_ready`, and addr/data are latched. `cmd_ready`=0 in every other state, and commands presented then are ignored.
- WRITE: IDLE→WR. In WR, `rf_we`=1 with `rf_wa`/`rf_wd` set to the latched values for exactly one cycle, then →IDLE. No response beat.
- READ: IDLE→RD. In RD, `rf_ra`=addr, and `rf_rdata` is captured into the response register at the end of the cycle. →RSP. RSP holds `rsp_valid`=1, `rsp_last`=1 until `rsp_ready`, then →IDLE.
- DUMP: 4-bit index idx=0. DMP_RD drives `rf_ra`=idx and captures the value. DMP_RSP presents {data, `rsp_addr`=idx} and waits for `rsp_ready`. On the handshake, if idx<NUM_REGS-1, idx++ and →DMP_RD; else →IDLE, or →CSUM with the macro. `rsp_last`=1 on idx=15 only without the macro.
- CLEAR: idx=0. CLR drives `rf_we`=1, `rf_wa`=idx, `rf_wd`=0 every cycle and increments idx. After idx=15 →IDLE. Always 16 write cycles, and it cannot be stalled.
- idx wraps 15→0 by width. Termination is decided by the compare, never by the wrap.
- Outside WR/CLR: `rf_we`=0 and `rf_wa`/`rf_wd`=0. Outside RD/DMP_RD: `rf_ra`=0.
- Response beat is stable (data/addr/last) while `rsp_valid`=1 and `rsp_ready`=0.
- The block never reads a register in the cycle it writes it, so there is no read/write hazard to handle.

## Timing
- Reset (async assert, sync release): all outputs 0, including `cmd_ready`, state IDLE, idx 0. The first cycle after release has `cmd_ready`=1.
- Reset mid-command aborts it immediately. `rf_we` drops in the same instant and no response is emitted. Registers already written by a partial CLEAR/WRITE stay written, because the register file is not reset here.
- Command accepted at edge N:
  - WRITE: `rf_we` high during cycle N+1; data visible on `read_a` from N+2; `cmd_ready` at N+2.
  - READ: `rsp_valid` from N+2 at the earliest; `cmd_ready` the cycle after the response handshake.
  - DUMP: 2 cycles per register with `rsp_ready` tied high, so 32 cycles (34 with checksum) until `cmd_ready`.
  - CLEAR: writes in cycles N+1..N+16; `cmd_ready` at N+17.
- `busy` = not IDLE; it is registered together with the state.

## Configuration
- `REG_DBG_CHECKSUM_EN` defined: DUMP keeps a running XOR of the 16 values and sends a 17th beat from CSUM with `rsp_data`=XOR, `rsp_addr`=0, `rsp_last`=1. Beat 15 has `rsp_last`=0.
- Undefined: no CSUM state and no accumulator; DUMP ends on beat 15 with `rsp_last`=1.

## Structure
- Package `reg_dbg_pkg` holds:
  - the op encoding enum (READ/WRITE/DUMP/CLEAR)
  - the state enum
  - `NUM_REGS`, `ADDR_W`, `DATA_W` constants
- One sub-module: `reg_dbg_rsp_slot`, a single-entry output holding register that owns `rsp_valid`/`rsp_data`/`rsp_addr`/`rsp_last` and the valid/ready hold rule. Everything else is in the top FSM.

## Test plan
- WRITE each i=0..15 with data i*0x11, then READ addr 3 → one beat with `rsp_data`=0x33, `rsp_addr`=3, `rsp_last`=1, and `rf_we` pulsed exactly 16 times.
- DUMP after the fill, `rsp_ready` toggling every other cycle → 16 beats addr 0..15, data 0x00..0xFF, each stable while stalled, `rsp_last` on addr 15. With the macro: 17th beat data 0x00 (XOR of the fill), `rsp_last` only on it.
- WRITE addr 3 = 0xAA, then READ 3 → 0xAA. Commands held valid during the busy cycles are not accepted (`cmd_ready`=0), and no beat is duplicated.
- CLEAR → `rf_we` high exactly 16 consecutive cycles with `rf_wa`=0..15 and `rf_wd`=0; `cmd_ready` returns at N+17; a following DUMP returns all 0x00.
- Assert `rst` during CLEAR at idx=7 → `rf_we`/`busy`/`rsp_valid` drop at once. Registers 0..6 read 0 and 7..15 keep their old values; `cmd_ready`=1 the first cycle after release.
- READ with `rsp_ready` held low for 10 cycles → `rsp_valid` held and data unchanged, `cmd_ready`=0 throughout, and IDLE one cycle after the handshake.

Source files
------------

// File: rtl/reg_dbg_pkg.sv
// Shared types and sizes for the register-file debug port.
// REG_DBG_CHECKSUM_EN adds the CSUM state (XOR beat after a DUMP).
package reg_dbg_pkg;

  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 1 << ADDR_W;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_DUMP  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RSP,
    S_DMP_RD,
    S_DMP_RSP,
    S_CLR
`ifdef REG_DBG_CHECKSUM_EN
    , S_CSUM
`endif
  } state_e;

endpackage

// File: rtl/reg_dbg_rsp_slot.sv
// Single-entry response holding register. A load fills the slot and raises
// rsp_valid; the beat stays frozen until the consumer takes it.
module reg_dbg_rsp_slot #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              load_last,
  input  logic              rsp_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_last
);

  // Fill on load (only issued while empty), drain on handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_addr  <= '0;
      rsp_last  <= 1'b0;
    end else if (load) begin
      rsp_valid <= 1'b1;
      rsp_data  <= load_data;
      rsp_addr  <= load_addr;
      rsp_last  <= load_last;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/reg_file_debug_port.sv
// Debug command initiator for the 16x8 register file: READ, WRITE, DUMP
// and CLEAR become register-file port activity; read values come back on
// a valid/ready response channel. REG_DBG_CHECKSUM_EN appends an XOR
// checksum beat to DUMP.
module reg_file_debug_port #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_last,
  output logic              busy,
  output logic [ADDR_W-1:0] rf_ra,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic              rf_we
);

  import reg_dbg_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_e            state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] addr_q;
  logic              hs;

  logic              slot_load;
  logic [DATA_W-1:0] slot_data;
  logic [ADDR_W-1:0] slot_addr;
  logic              slot_last;

`ifdef REG_DBG_CHECKSUM_EN
  logic [DATA_W-1:0] csum;
`endif

  assign hs = rsp_valid && rsp_ready;

  // Select what the response slot captures at the end of a read cycle.
  always_comb begin
    slot_load = 1'b0;
    slot_data = rf_rdata;
    slot_addr = addr_q;
    slot_last = 1'b1;
    case (state)
      S_RD: slot_load = 1'b1;
      S_DMP_RD: begin
        slot_load = 1'b1;
        slot_addr = idx;
`ifdef REG_DBG_CHECKSUM_EN
        slot_last = 1'b0;
`else
        slot_last = (idx == LAST_IDX);
`endif
      end
`ifdef REG_DBG_CHECKSUM_EN
      // Load once on entry; the slot then holds the beat until taken.
      S_CSUM: begin
        slot_load = !rsp_valid;
        slot_data = csum;
        slot_addr = '0;
      end
`endif
      default: ;
    endcase
  end

  // Command FSM; register-file strobes are registered with the state so
  // they are valid for the whole cycle the state is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      addr_q    <= '0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      rf_we     <= 1'b0;
      rf_wa     <= '0;
      rf_wd     <= '0;
      rf_ra     <= '0;
`ifdef REG_DBG_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      rf_we <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
      rf_ra <= '0;
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            addr_q    <= cmd_addr;
            idx       <= '0;
            case (op_e'(cmd_op))
              OP_WRITE: begin
                state <= S_WR;
                rf_we <= 1'b1;
                rf_wa <= cmd_addr;
                rf_wd <= cmd_data;
              end
              OP_READ: begin
                state <= S_RD;
                rf_ra <= cmd_addr;
              end
              OP_DUMP: begin
                state <= S_DMP_RD;
`ifdef REG_DBG_CHECKSUM_EN
                csum  <= '0;
`endif
              end
              OP_CLEAR: begin
                state <= S_CLR;
                rf_we <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_WR: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        S_RD: state <= S_RSP;
        S_RSP: begin
          if (hs) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        S_DMP_RD: begin
          state <= S_DMP_RSP;
`ifdef REG_DBG_CHECKSUM_EN
          csum  <= csum ^ rf_rdata;
`endif
        end
        S_DMP_RSP: begin
          if (hs) begin
            idx <= idx + 1'b1;
            if (idx != LAST_IDX) begin
              state <= S_DMP_RD;
              rf_ra <= idx + 1'b1;
            end else begin
`ifdef REG_DBG_CHECKSUM_EN
              state     <= S_CSUM;
`else
              state     <= S_IDLE;
              busy      <= 1'b0;
              cmd_ready <= 1'b1;
`endif
            end
          end
        end
        // Sixteen back-to-back zero writes; never waits on anything.
        S_CLR: begin
          idx <= idx + 1'b1;
          if (idx != LAST_IDX) begin
            rf_we <= 1'b1;
            rf_wa <= idx + 1'b1;
          end else begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
`ifdef REG_DBG_CHECKSUM_EN
        S_CSUM: begin
          if (hs) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  reg_dbg_rsp_slot #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_rsp_slot (
    .clk      (clk),
    .rst      (rst),
    .load     (slot_load),
    .load_data(slot_data),
    .load_addr(slot_addr),
    .load_last(slot_last),
    .rsp_ready(rsp_ready),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_addr (rsp_addr),
    .rsp_last (rsp_last)
  );

endmodule

// File: tb/tb_reg_file_debug_port.sv
// Bench for reg_file_debug_port: behavioural register file, command-level
// model with expected beat/write queues, per-cycle compare, directed tests.
`timescale 1ns/1ps
module tb_reg_file_debug_port;

  localparam logic [1:0] OPR = 2'b00, OPW = 2'b01, OPD = 2'b10, OPC = 2'b11;
`ifdef REG_DBG_CHECKSUM_EN
  localparam bit DUMP_LAST_15 = 1'b0;
  localparam int DUMP_CYC     = 34;
`else
  localparam bit DUMP_LAST_15 = 1'b1;
  localparam int DUMP_CYC     = 32;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_addr = 4'h0;
  logic [7:0] cmd_data = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic [3:0] rsp_addr;
  logic       rsp_last;
  logic       busy;
  logic [3:0] rf_ra;
  logic [7:0] rf_rdata;
  logic [3:0] rf_wa;
  logic [7:0] rf_wd;
  logic       rf_we;

  reg_file_debug_port dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_addr(rsp_addr), .rsp_last(rsp_last), .busy(busy),
    .rf_ra(rf_ra), .rf_rdata(rf_rdata),
    .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_we(rf_we)
  );

  always #5 clk = ~clk;

  // Register file: synchronous write, combinational read, not reset.
  logic [7:0] rf [16];
  always @(posedge clk) if (rf_we) rf[rf_wa] <= rf_wd;
  assign rf_rdata = rf[rf_ra];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: register contents plus the outstanding beats and writes.
  logic [7:0]  mem [16];
  logic [12:0] bq [$];   // {data, addr, last}
  logic [11:0] wq [$];   // {addr, data}
  int          we_count = 0;
  logic [12:0] last_beat = '0;

  // rsp_ready: 0 = high, 1 = toggle every cycle, 2 = low.
  int rdy_mode = 0;
  initial forever begin
    @(posedge clk); #2;
    case (rdy_mode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = ~rsp_ready;
      default: rsp_ready = 1'b0;
    endcase
  end

  // Per-cycle compare against the model.
  initial begin
    logic prev_rst;
    prev_rst = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("reset_outputs",
              {cmd_ready, busy, rsp_valid, rsp_last, rf_we, rf_wa, rf_wd, rf_ra, rsp_data, rsp_addr}, 0);
      end else begin
        if (rf_we) begin
          we_count++;
          if (wq.size() == 0) check("write_unexpected", 1, 0);
          else begin
            check("write_port", {rf_wa, rf_wd}, wq[0]);
            wq.delete(0);
          end
        end else begin
          check("write_port_idle", {rf_wa, rf_wd}, 0);
        end
        if (rsp_valid) begin
          if (bq.size() == 0) check("beat_unexpected", 1, 0);
          else begin
            check("beat", {rsp_data, rsp_addr, rsp_last}, bq[0]);
            if (rsp_ready) begin
              last_beat = {rsp_data, rsp_addr, rsp_last};
              bq.delete(0);
            end
          end
        end
        if (!prev_rst) check("busy_vs_ready", busy, !cmd_ready);
      end
      prev_rst = rst;
    end
  end

  task automatic send(input logic [1:0] op, input logic [3:0] a, input logic [7:0] d);
    bit ok;
    logic [7:0] x;
    ok = 0;
    x  = 8'h00;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (!ok) begin check("cmd_accept_timeout", 0, 1); return; end
    case (op)
      OPR: bq.push_back({mem[a], a, 1'b1});
      OPW: begin wq.push_back({a, d}); mem[a] = d; end
      OPD: begin
        for (int i = 0; i < 16; i++) begin
          bq.push_back({mem[i], 4'(i), DUMP_LAST_15 && (i == 15)});
          x ^= mem[i];
        end
`ifdef REG_DBG_CHECKSUM_EN
        bq.push_back({x, 4'h0, 1'b1});
`endif
      end
      default: for (int i = 0; i < 16; i++) begin
        wq.push_back({4'(i), 8'h00});
        mem[i] = 8'h00;
      end
    endcase
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (cmd_ready && bq.size() == 0 && wq.size() == 0) begin ok = 1; break; end
    end
    check(name, ok, 1);
  endtask

  task automatic wait_rsp(input string name);
    bit ok;
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1; break; end
    end
    check(name, ok, 1);
  endtask

  initial begin
    logic [7:0] saved [16];
    bit hit;
    int k;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;

    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_reset", {cmd_ready, busy}, 2'b10);

    // Fill, then read back one register.
    for (int i = 0; i < 16; i++) begin
      send(OPW, 4'(i), 8'(i * 17));
      wait_idle("fill_idle");
    end
    check("fill_we_count", we_count, 16);
    send(OPR, 4'd3, 8'h00);
    wait_rsp("read3_rsp");
    check("read3_beat", {rsp_data, rsp_addr, rsp_last}, {8'h33, 4'd3, 1'b1});
    wait_idle("read3_idle");
    check("read_no_write", we_count, 16);

    // Dump with a stalling consumer.
    rdy_mode = 1;
    send(OPD, 4'h0, 8'h00);
    wait_idle("dump_toggle_idle");
`ifdef REG_DBG_CHECKSUM_EN
    check("dump_final_beat", last_beat, {8'h00, 4'h0, 1'b1});
`else
    check("dump_final_beat", last_beat, {8'hFF, 4'hF, 1'b1});
`endif
    rdy_mode = 0;

    // WRITE timing, then a long-stalled READ with a command held valid.
    send(OPW, 4'd3, 8'hAA);
    check("wr_we_n1", {rf_we, rf_wa, rf_wd, cmd_ready}, {1'b1, 4'd3, 8'hAA, 1'b0});
    @(posedge clk); #1;
    check("wr_ready_n2", {rf_we, cmd_ready}, 2'b01);
    rdy_mode = 2;
    wait_idle("wr_idle");
    send(OPR, 4'd3, 8'h00);
    cmd_valid = 1'b1; cmd_op = OPW; cmd_addr = 4'd3; cmd_data = 8'h55;
    wait_rsp("stall_rsp");
    for (int i = 0; i < 10; i++) begin
      check("stall_hold", {rsp_valid, rsp_data, rsp_addr, rsp_last, cmd_ready},
            {1'b1, 8'hAA, 4'd3, 1'b1, 1'b0});
      @(negedge clk);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rdy_mode  = 0;
    @(posedge clk); #1;
    check("idle_after_hs", {rsp_valid, cmd_ready}, 2'b01);
    wait_idle("stall_idle");
    check("held_cmd_ignored", we_count, 17);
    send(OPR, 4'd3, 8'h00);
    wait_rsp("reread_rsp");
    check("reread3", rsp_data, 8'hAA);
    wait_idle("reread_idle");

    // CLEAR timing, then dump the cleared file.
    send(OPC, 4'h0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      check("clr_we", {rf_we, rf_wa, rf_wd, cmd_ready}, {1'b1, 4'(i), 8'h00, 1'b0});
      @(posedge clk); #1;
    end
    check("clr_ready_n17", {cmd_ready, rf_we}, 2'b10);
    send(OPD, 4'h0, 8'h00);
    k = 0;
    while (!cmd_ready && k < 100) begin @(posedge clk); #1; k++; end
    check("dump_cycles", k, DUMP_CYC);
    wait_idle("dump_zero_idle");

    // Refill, then reset in the middle of a CLEAR.
    for (int i = 0; i < 16; i++) begin
      send(OPW, 4'(i), 8'hC0 | 8'(i));
      wait_idle("refill_idle");
    end
    for (int i = 0; i < 16; i++) saved[i] = mem[i];
    send(OPC, 4'h0, 8'h00);
    hit = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rf_we && rf_wa == 4'd7) begin hit = 1; break; end
    end
    check("clr_reached_7", hit, 1);
    #1 rst = 1'b1;
    #1 check("abort_drop", {rf_we, busy, rsp_valid}, 3'b000);
    check("abort_writes_left", wq.size(), 8);
    wq.delete();
    bq.delete();
    for (int i = 7; i < 16; i++) mem[i] = saved[i];
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_abort", cmd_ready, 1);
    send(OPR, 4'd6, 8'h00);
    wait_rsp("abort_r6_rsp");
    check("abort_reg6", rsp_data, 8'h00);
    wait_idle("abort_r6_idle");
    send(OPR, 4'd7, 8'h00);
    wait_rsp("abort_r7_rsp");
    check("abort_reg7", rsp_data, 8'hC7);
    wait_idle("abort_r7_idle");
    send(OPD, 4'h0, 8'h00);
    wait_idle("abort_dump_idle");

    check("queues_empty", bq.size() + wq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global bound so a stuck DUT can never hang the run.
  initial begin
    #400000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
